// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the front end and control path.
//   XLEN / INSTR_W       : address and instruction widths
//   RESET_PC_DEFAULT     : PC loaded by reset unless overridden
//   addr_t               : XLEN-wide address type
//   fetch_state_e        : fetch-stage sequencing states
//   OP_*                 : major op-code values (instr[6:0]) used by decode
package rv32i_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [XLEN-1:0] addr_t;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Word-align an address by clearing the byte offset.
  function automatic addr_t align_word(input addr_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO with synchronous flush.
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : write data_i at the tail (ignored when full unless popping)
//   pop_i      : remove the head (ignored when empty)
//   flush_i    : discard all entries; takes priority over push/pop
//   data_i     : tail write data
//   data_o     : head data, combinational; zero while empty
//   count_o    : number of valid entries
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  import rv32i_pkg::*;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A full FIFO may still accept a push in the same cycle as a pop: the
  // head slot is read combinationally before the write lands on it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage carries no reset; emptiness is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage.
//   clk, rst                       : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr      : word fetch request to instruction memory
//   imem_rsp_valid/data            : in-order instruction responses
//   redirect_valid/pc              : flush the stage and restart at redirect_pc
//   instr_valid/ready/data/pc      : buffered instruction handed to decode
module fetch_unit #(
  parameter int              XLEN     = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv32i_pkg::RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc
);
  import rv32i_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int BUF_W = XLEN + INSTR_W;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] out_q, out_d;    // requests accepted, response not yet seen
  logic [CNT_W-1:0] drop_q, drop_d;  // of those, how many belong to a stale stream

  logic             redir;
  logic             req_fire;
  logic             rsp_live;
  logic             rsp_keep;
  logic             buf_pop;
  logic [BUF_W-1:0] buf_wdata;
  logic [BUF_W-1:0] buf_rdata;
  logic [CNT_W-1:0] buf_count;
  logic             buf_full;
  logic             buf_empty;
  logic [XLEN-1:0]  pcf_rdata;
  logic [CNT_W-1:0] pcf_count;
  logic             pcf_full;
  logic             pcf_empty;
  logic             unused_sig;

  // Redirects are only meaningful once the stage is out of reset.
  assign redir = redirect_valid && (state_q != S_RESET);

  // Outstanding requests plus buffered entries never exceed DEPTH, so every
  // live response is guaranteed a buffer slot.
  assign imem_req_valid = (state_q != S_RESET) && !redirect_valid &&
                          (({1'b0, out_q} + {1'b0, buf_count}) < SUM_W'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses counted in drop are discarded; the rest belong to the current
  // stream and consume the matching entry of the request-PC FIFO.
  assign rsp_live  = imem_rsp_valid && (drop_q == '0);
  assign rsp_keep  = rsp_live && !redir;
  assign buf_pop   = instr_valid && instr_ready && !redir;
  assign buf_wdata = {pcf_rdata, imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH), .W(XLEN)) u_pc_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_fire),
    .pop_i   (rsp_live),
    .flush_i (redir),
    .data_i  (pc_q),
    .data_o  (pcf_rdata),
    .count_o (pcf_count),
    .full_o  (pcf_full),
    .empty_o (pcf_empty)
  );

  fetch_fifo #(.DEPTH(DEPTH), .W(BUF_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_keep),
    .pop_i   (buf_pop),
    .flush_i (redir),
    .data_i  (buf_wdata),
    .data_o  (buf_rdata),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  assign instr_valid = !buf_empty;
  assign instr_data  = buf_rdata[INSTR_W-1:0];
  assign instr_pc    = buf_rdata[BUF_W-1:INSTR_W];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    out_d   = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    if (req_fire) pc_d = pc_q + XLEN'(4);
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);

    // No request fires in a redirect cycle, so out_d is exactly what is
    // still in flight after this cycle's response; all of it is now stale.
    if (redir) begin
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d = out_d;
    end

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: if (redir && (drop_d != '0)) state_d = S_DRAIN;
      S_DRAIN: if (drop_d == '0) state_d = S_FETCH;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  a_rsp_not_full: assert property (@(posedge clk) disable iff (rst)
                                   !(imem_rsp_valid && buf_full));
  a_rsp_has_pc:   assert property (@(posedge clk) disable iff (rst)
                                   !(rsp_live && pcf_empty));

  assign unused_sig = ^{1'b0, redirect_pc[1:0], pcf_count, pcf_full, pcf_empty, buf_full};

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;

  // memory model: accepted requests waiting to be answered
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  // observed transactions
  logic [31:0] acc_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_dat_q[$];
  logic        acc_s;
  logic        rsp_s;
  logic [31:0] acc_addr;

  typedef struct {
    logic        rrdy;
    logic        irdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
  } vec_t;
  vec_t vt[8];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (acc_q.size() > i) ? acc_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pop_pc_at(input int i);
    return (pop_pc_q.size() > i) ? pop_pc_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pop_dat_at(input int i);
    return (pop_dat_q.size() > i) ? pop_dat_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Mid-cycle: sample outputs and record the handshakes of this cycle.
  task automatic mid();
    @(negedge clk);
    acc_s    = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    rsp_s    = imem_rsp_valid;
    if (acc_s) acc_q.push_back(imem_req_addr);
    if (instr_valid && instr_ready && !redirect_valid) begin
      pop_pc_q.push_back(instr_pc);
      pop_dat_q.push_back(instr_data);
    end
  endtask

  // Edge: advance the memory model and drive this cycle's response.
  task automatic fin();
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_s) begin
      mq_addr.delete(0);
      mq_due.delete(0);
    end
    if (acc_s) begin
      mq_addr.push_back(acc_addr);
      mq_due.push_back(cyc + lat - 1);
    end
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic cycle();
    mid();
    fin();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    acc_s          = 1'b0;
    rsp_s          = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    acc_q.delete();
    pop_pc_q.delete();
    pop_dat_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_acc(input int n, input string nm);
    int k = 0;
    while (acc_q.size() < n && k < 40) begin
      cycle();
      k++;
    end
    chk(nm, 32'(acc_q.size() >= n), 32'd1);
  endtask

  task automatic wait_pop(input int n, input string nm);
    int k = 0;
    while (pop_pc_q.size() < n && k < 40) begin
      cycle();
      k++;
    end
    chk(nm, 32'(pop_pc_q.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;

    // free-running fetch, 1-cycle memory, decode always ready
    vt[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vt[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    vt[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
    vt[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};

    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_req_valid",   32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_data",  instr_data, 32'h0);
    chk("rst_instr_pc",    instr_pc, 32'h0);
    chk("rst_req_addr",    imem_req_addr, 32'h0);

    // 1: table-driven streaming
    lat = 1;
    do_reset();
    chk("t_state_reset", 32'(dut.state_q), 32'(S_RESET));
    for (int i = 0; i < 8; i++) begin
      imem_req_ready = vt[i].rrdy;
      instr_ready    = vt[i].irdy;
      mid();
      chk($sformatf("t%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].e_rv));
      if (vt[i].e_rv) chk($sformatf("t%0d_req_addr", i), imem_req_addr, vt[i].e_addr);
      chk($sformatf("t%0d_instr_valid", i), 32'(instr_valid), 32'(vt[i].e_iv));
      if (vt[i].e_iv) begin
        chk($sformatf("t%0d_instr_pc", i), instr_pc, vt[i].e_ipc);
        chk($sformatf("t%0d_instr_data", i), instr_data, memf(vt[i].e_ipc));
      end
      fin();
    end

    // 2: decode stalled -> exactly DEPTH requests, then in-order drain
    lat = 1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    do_reset();
    repeat (10) cycle();
    mid();
    chk("stall_req_count", 32'(acc_q.size()), 32'd2);
    chk("stall_acc0", acc_at(0), 32'h0);
    chk("stall_acc1", acc_at(1), 32'h4);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_count", 32'(dut.buf_count), 32'd2);
    chk("stall_head_pc", instr_pc, 32'h0);
    fin();
    instr_ready = 1'b1;
    wait_pop(3, "stall_pop_wait");
    wait_acc(3, "stall_acc_wait");
    chk("stall_pop0", pop_pc_at(0), 32'h0);
    chk("stall_pop1", pop_pc_at(1), 32'h4);
    chk("stall_pop2", pop_pc_at(2), 32'h8);
    chk("stall_dat1", pop_dat_at(1), memf(32'h4));
    chk("stall_acc2", acc_at(2), 32'h8);

    // 3: redirect with two requests outstanding (3-cycle memory)
    lat = 3;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    do_reset();
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    mid();
    chk("redir_outstanding", 32'(acc_q.size()), 32'd2);
    chk("redir_req_suppressed", 32'(imem_req_valid), 32'd0);
    fin();
    redirect_valid = 1'b0;
    mid();
    chk("redir_state_drain", 32'(dut.state_q), 32'(S_DRAIN));
    fin();
    wait_pop(1, "redir_pop_wait");
    chk("redir_next_addr", acc_at(2), 32'h0000_0100);
    chk("redir_first_pc", pop_pc_at(0), 32'h0000_0100);
    chk("redir_first_dat", pop_dat_at(0), memf(32'h0000_0100));
    chk("redir_state_fetch", 32'(dut.state_q), 32'(S_FETCH));

    // 4: PC wrap via redirect to the top word; response in redirect cycle dropped
    lat = 1;
    do_reset();
    repeat (2) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    wait_acc(3, "wrap_acc_wait");
    wait_pop(2, "wrap_pop_wait");
    chk("wrap_acc1", acc_at(1), 32'hFFFF_FFFC);
    chk("wrap_acc2", acc_at(2), 32'h0000_0000);
    chk("wrap_pop0", pop_pc_at(0), 32'hFFFF_FFFC);
    chk("wrap_pop1", pop_pc_at(1), 32'h0000_0000);
    chk("wrap_dat1", pop_dat_at(1), memf(32'h0));

    // 5: memory not ready -> address held at 0x8
    lat = 1;
    do_reset();
    wait_acc(2, "hold_acc_wait");
    imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk($sformatf("hold%0d_addr", k), imem_req_addr, 32'h8);
      if (k == 4) chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
      fin();
    end
    imem_req_ready = 1'b1;
    wait_acc(3, "hold_resume_wait");
    chk("hold_acc2", acc_at(2), 32'h8);

    // 6: asynchronous reset with the buffer full
    lat = 1;
    instr_ready = 1'b0;
    do_reset();
    repeat (6) cycle();
    mid();
    chk("full_instr_valid", 32'(instr_valid), 32'd1);
    chk("full_count", 32'(dut.buf_count), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("arst_instr_valid", 32'(instr_valid), 32'd0);
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    do_reset();
    instr_ready = 1'b1;
    wait_pop(1, "arst_pop_wait");
    chk("arst_acc0", acc_at(0), 32'h0);
    chk("arst_pop0", pop_pc_at(0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32I core, directly upstream of the control/decode block.
- Holds the PC, issues word requests to instruction memory, and buffers returned instructions in a small in-order FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Decode extracts op_code = instr_data[6:0], func3 = [14:12] and func7 = [31:25] from instr_data.
- A redirect input (branch/jump target from execute) flushes the stage and restarts fetch.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PC after reset.
- DEPTH, 2, instruction buffer entries; also the maximum in-flight requests plus buffered entries.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response data valid; responses return in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new PC; bits [1:0] are ignored and forced to 0.
- instr_valid  out  1  buffer head is valid.
- instr_ready  in  1  decode consumes the head.
- instr_data  out  32  head instruction.
- instr_pc  out  XLEN  PC of the head instruction.

Behaviour:
- Reset (async assert, sync deassert use):
  - pc = RESET_PC; buffer empty; outstanding = 0; drop = 0.
  - imem_req_valid = 0, instr_valid = 0, instr_data = 0, instr_pc = 0.
  - FSM enters S_RESET.
- FSM:
  - S_RESET -> S_FETCH unconditionally on the first clk after reset deasserts; no request is issued in S_RESET.
  - S_FETCH: normal operation.
  - S_FETCH -> S_DRAIN on redirect_valid while (outstanding - drop) > 0 after the flush is applied.
  - S_DRAIN -> S_FETCH when drop reaches 0. Requests are allowed in S_DRAIN.
- Request issue:
  - imem_req_valid = 1 in S_FETCH/S_DRAIN when outstanding + count < DEPTH and redirect_valid = 0.
  - imem_req_addr = pc.
  - Request accepted (valid & ready): pc <= pc + 4, wrapping modulo 2^XLEN; outstanding++.
  - Request address and valid stay stable until accepted, unless a redirect occurs.
- Response handling:
  - Each imem_rsp_valid decrements outstanding.
  - If drop > 0: drop-- and the data is discarded.
  - Otherwise the data is written to the buffer tail with its PC, taken from a parallel PC FIFO captured at request acceptance.
  - Buffer never overflows by construction. A response arriving with a full buffer is an assertion failure.
- Output:
  - instr_valid = (count > 0); head is combinational from the buffer.
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle leaves count unchanged, including when full.
  - Bypass from response to output is not allowed: minimum latency from request acceptance to instr_valid is 2 cycles with a 1-cycle memory.
- Redirect (redirect_valid = 1 in any non-reset state), all applied in the same cycle:
  - Buffer flushed to count = 0, so instr_valid = 0 next cycle.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - drop <= outstanding minus any response accepted this cycle, excluding responses already being dropped.
  - A request handshake in the redirect cycle is suppressed (imem_req_valid = 0).
  - A response arriving in the redirect cycle is discarded and counted.
  - Redirect during S_DRAIN adds the new outstanding count to drop.
- Simultaneous redirect and instr_ready: the pop is ignored; the flush wins.
- Reset mid-operation: all state cleared immediately. In-flight memory responses after reset are the memory's responsibility (memory is reset on the same rst).

Decomposition:
- Package rv32i_pkg holds:
  - XLEN, RESET_PC_DEFAULT, INSTR_W = 32.
  - typedef logic [XLEN-1:0] addr_t.
  - typedef enum logic [1:0] {S_RESET, S_FETCH, S_DRAIN} fetch_state_e.
  - op-code constants shared with control, e.g. OP_LOAD = 7'b0000011.
- One natural sub-module: fetch_fifo, a parameterised DEPTH-entry FIFO of {pc, instr} with push/pop/flush, count, full, empty.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, instr_ready = 1 -> req addrs 0x0, 0x4, 0x8…; first instr_valid 2 cycles after the first acceptance, instr_pc = 0x0.
- instr_ready = 0 for 10 cycles -> exactly DEPTH = 2 requests issued, then imem_req_valid = 0; count = 2. Releasing ready drains 0x0, 0x4 in order and fetching resumes at 0x8.
- Redirect to 0x0000_0103 with 2 requests outstanding -> next req addr 0x100; the 2 stale responses are discarded; first instr_pc = 0x100; state passes through S_DRAIN.
- PC at 0xFFFF_FFFC accepted -> next req addr 0x0000_0000 (wrap).
- imem_req_ready held low for 5 cycles -> imem_req_addr stays stable at 0x8 and pc is not advanced.
- Assert rst mid-stream with the buffer full -> same cycle instr_valid = 0 and imem_req_valid = 0; after release, fetch restarts at RESET_PC.
